// File: rtl/sub32_pkg.sv
// Shared constants and types for the 32-bit subtract unit.
// Optional signed-overflow output is enabled by defining SUB32_OVF_EN.
package sub32_pkg;

   localparam int SUB32_WIDTH  = 32;
   localparam int SUB32_SLICE  = 4;
   localparam int SUB32_NSLICE = SUB32_WIDTH / SUB32_SLICE;

   typedef logic [31:0] word_t;

endpackage : sub32_pkg

// File: rtl/sub_4bit_bla.sv
// 4-bit borrow-lookahead subtract slice: d = a - b - bin, with group generate/propagate.
// A borrow is generated where a=0,b=1 and propagated where a==b.
module sub_4bit_bla (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout,
   output logic       grp_g,
   output logic       grp_p
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [3:0] w_bor;

   assign w_g = ~a & b;
   assign w_p = ~(a ^ b);

   // Borrow into each bit, flattened so no bit waits on its neighbour.
   assign w_bor[0] = bin;
   assign w_bor[1] = w_g[0] | (w_p[0] & bin);
   assign w_bor[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
   assign w_bor[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & bin);

   assign grp_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign grp_p = &w_p;
   assign bout  = grp_g | (grp_p & bin);

   assign d = a ^ b ^ w_bor;

endmodule : sub_4bit_bla

// File: rtl/sub_32bit.sv
// Registered 32-bit subtractor: sum = Ra - Rb - cin, cout = borrow, one cycle latency.
// Define SUB32_OVF_EN to add the registered signed-overflow output ovf.
module sub_32bit
   import sub32_pkg::*;
(
   input  logic        clk,
   input  logic        clr_n,
   input  logic [31:0] Ra,
   input  logic [31:0] Rb,
   input  logic        cin,
`ifdef SUB32_OVF_EN
   output logic        ovf,
`endif
   output logic [31:0] sum,
   output logic        cout
);

   word_t                   w_diff;
   logic [SUB32_NSLICE:0]   w_borrow;
   logic [SUB32_NSLICE-1:0] w_grp_g;
   logic [SUB32_NSLICE-1:0] w_grp_p;
   logic                    w_gp_unused;

   word_t r_sum;
   logic  r_cout;

   assign w_borrow[0] = cin;

   // Borrow ripples slice to slice; lookahead is inside each slice.
   for (genvar gi = 0; gi < SUB32_NSLICE; gi++) begin : g_slice
      sub_4bit_bla u_slice (
         .a     (Ra[gi*SUB32_SLICE +: SUB32_SLICE]),
         .b     (Rb[gi*SUB32_SLICE +: SUB32_SLICE]),
         .bin   (w_borrow[gi]),
         .d     (w_diff[gi*SUB32_SLICE +: SUB32_SLICE]),
         .bout  (w_borrow[gi+1]),
         .grp_g (w_grp_g[gi]),
         .grp_p (w_grp_p[gi])
      );
   end

   // Group terms are kept on the slice for a future two-level lookahead.
   assign w_gp_unused = ^{w_grp_g, w_grp_p};

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else begin
         r_sum  <= w_diff;
         r_cout <= w_borrow[SUB32_NSLICE];
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

`ifdef SUB32_OVF_EN
   logic w_ovf;
   logic r_ovf;

   // Overflow only when operand signs differ and the result sign leaves Ra's.
   assign w_ovf = (Ra[SUB32_WIDTH-1] != Rb[SUB32_WIDTH-1]) &&
                  (w_diff[SUB32_WIDTH-1] != Ra[SUB32_WIDTH-1]);

   always_ff @(posedge clk) begin
      if (!clr_n) r_ovf <= 1'b0;
      else        r_ovf <= w_ovf;
   end

   assign ovf = r_ovf;
`endif

endmodule : sub_32bit

// File: tb/tb_sub_32bit.sv
// Self-checking bench for sub_32bit: directed vector table, reset sequences, random back-to-back stream.
// Compile with SUB32_OVF_EN defined to also check ovf.
module tb_sub_32bit;

   typedef struct {
      logic [31:0] ra;
      logic [31:0] rb;
      logic        cin;
      logic [31:0] e_sum;
      logic        e_cout;
      logic        e_ovf;
   } vec_t;

   typedef struct {
      logic [31:0] e_sum;
      logic        e_cout;
      logic        e_ovf;
   } exp_t;

   logic        clk;
   logic        clr_n;
   logic [31:0] Ra;
   logic [31:0] Rb;
   logic        cin;
   logic [31:0] sum;
   logic        cout;
   logic        ovf_s;

   int n_cmp;
   int n_bad;

   vec_t vecs[5];
   exp_t exp_q[$];

   sub_32bit dut (
      .clk   (clk),
      .clr_n (clr_n),
      .Ra    (Ra),
      .Rb    (Rb),
      .cin   (cin),
`ifdef SUB32_OVF_EN
      .ovf   (ovf_s),
`endif
      .sum   (sum),
      .cout  (cout)
   );

`ifndef SUB32_OVF_EN
   assign ovf_s = 1'b0;
`endif

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: plain wide arithmetic straight from the operation rules
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
      exp_t        r;
      longint      ua;
      longint      ub;
      longint      sd;
      logic [32:0] full;
      ua   = longint'({32'd0, a});
      ub   = longint'({32'd0, b});
      full = {1'b0, a} - {1'b0, b} - {32'd0, c};
      r.e_sum  = full[31:0];
      r.e_cout = (ua < ub + longint'(c));
      sd = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
`ifdef SUB32_OVF_EN
      r.e_ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
`else
      r.e_ovf = 1'b0;
      if (sd == 0) r.e_ovf = 1'b0;
`endif
      return r;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   task automatic check_all(input string name, input exp_t e);
      check32({name, ".sum"}, sum, e.e_sum);
      check1({name, ".cout"}, cout, e.e_cout);
`ifdef SUB32_OVF_EN
      check1({name, ".ovf"}, ovf_s, e.e_ovf);
`endif
   endtask

   // driver: inputs change on the falling edge, results sampled 1 ns after the rising edge
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c, input logic rn);
      @(negedge clk);
      Ra    = a;
      Rb    = b;
      cin   = c;
      clr_n = rn;
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      exp_t zero;
      n_cmp = 0;
      n_bad = 0;
      zero  = '{e_sum: 32'd0, e_cout: 1'b0, e_ovf: 1'b0};

      vecs[0] = '{ra: 32'h0000_0009, rb: 32'h0000_0001, cin: 1'b0, e_sum: 32'h0000_0008, e_cout: 1'b0, e_ovf: 1'b0};
      vecs[1] = '{ra: 32'hFFFF_FFFF, rb: 32'h0000_00FF, cin: 1'b1, e_sum: 32'hFFFF_FEFF, e_cout: 1'b0, e_ovf: 1'b0};
      vecs[2] = '{ra: 32'h0000_0000, rb: 32'h0000_0001, cin: 1'b0, e_sum: 32'hFFFF_FFFF, e_cout: 1'b1, e_ovf: 1'b0};
      vecs[3] = '{ra: 32'h0000_0000, rb: 32'h0000_0000, cin: 1'b1, e_sum: 32'hFFFF_FFFF, e_cout: 1'b1, e_ovf: 1'b0};
      vecs[4] = '{ra: 32'h1234_5678, rb: 32'h1234_5678, cin: 1'b1, e_sum: 32'hFFFF_FFFF, e_cout: 1'b1, e_ovf: 1'b0};

      Ra = 32'd0; Rb = 32'd0; cin = 1'b0; clr_n = 1'b0;

      // reset held for two edges with live operands
      drive(32'd5, 32'd1, 1'b0, 1'b0);
      drive(32'd5, 32'd1, 1'b0, 1'b0);
      check_all("reset", zero);

      // directed table
      for (int i = 0; i < 5; i++) begin
         drive(vecs[i].ra, vecs[i].rb, vecs[i].cin, 1'b1);
         e = '{e_sum: vecs[i].e_sum, e_cout: vecs[i].e_cout, e_ovf: vecs[i].e_ovf};
         check_all($sformatf("vec%0d", i), e);
      end

      // signed overflow edge, then reset overrides live inputs
      drive(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      e = '{e_sum: 32'h7FFF_FFFF, e_cout: 1'b0, e_ovf: 1'b1};
      check_all("ovf_edge", e);
      drive(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
      check_all("mid_reset", zero);
      // first result after reset comes from the first edge with clr_n high
      drive(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      e = '{e_sum: 32'h8000_0000, e_cout: 1'b1, e_ovf: 1'b1};
      check_all("post_reset", e);

      // random back-to-back stream, one new operand pair every cycle
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic        c;
         a = $urandom();
         b = (i % 8 == 0) ? a : $urandom();
         c = 1'($urandom_range(0, 1));
         if (i % 16 == 5) a = 32'h8000_0000 | $urandom_range(0, 15);
         @(negedge clk);
         if (exp_q.size() > 0) check_all("rand", exp_q.pop_front());
         Ra = a; Rb = b; cin = c; clr_n = 1'b1;
         exp_q.push_back(model(a, b, c));
      end
      @(negedge clk);
      while (exp_q.size() > 0) check_all("rand", exp_q.pop_front());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_sub_32bit

// File: doc/sub_32bit.md
# sub_32bit

Registered 32-bit two's-complement subtractor with borrow-in and borrow-out. It is the subtract unit of the datapath ALU and sits beside the 32-bit adder. It computes Ra − Rb − cin every clock and presents the difference and borrow one cycle later. Chained borrow ports allow multi-word subtraction.

## Interface
- Parameters: none. Width is fixed at 32 through the shared package constant `SUB32_WIDTH`.
- `clk`  input  1  rising-edge clock.
- `clr_n`  input  1  reset: one clock; reset is synchronous and active-low.
- `Ra`  input  32  minuend.
- `Rb`  input  32  subtrahend.
- `cin`  input  1  borrow-in; 1 subtracts an extra 1.
- `sum`  output  32  registered difference, Ra − Rb − cin mod 2^32.
- `cout`  output  1  registered borrow-out; 1 when the unsigned Ra < Rb + cin.
- `ovf`  output  1  registered signed overflow. Present only with `SUB32_OVF_EN` defined.

## Operation
- Combinational core: {borrow, diff} = {1'b0, Ra} − {1'b0, Rb} − cin, using full 33-bit arithmetic.
- Equivalent form: Ra + ~Rb + ~cin.
  - Carry-out of that addition is 1 when there is **no** borrow.
  - `cout` is the inverse of that carry, so it is the borrow.
- Operands are treated as unsigned for `cout`.
- `sum` bits are identical for the signed and unsigned interpretations.
- Results wrap modulo 2^32, with no saturation.
- With cin = 1 and Ra = Rb, the result is `sum` = 0xFFFF_FFFF with `cout` = 1.
- The internal structure is eight 4-bit borrow-lookahead slices with a rippled borrow between slices.
  - Only the function is checked.
  - The chosen structure must meet a single-cycle path at the datapath clock.
- No enable input: a new result is captured on every clock edge.

## Timing
- Inputs are sampled on the rising edge of `clk`.
- `sum`, `cout` and `ovf` update on that edge, giving a latency of 1 cycle and a throughput of 1 result per cycle.
- Reset values: `clr_n` = 0 at a rising edge sets `sum` = 0, `cout` = 0 and `ovf` = 0.
  - Reset has priority over any inputs present at the same edge.
- Reset mid-stream: the in-flight result is discarded.
  - The first result after reset comes from the inputs sampled at the first edge with `clr_n` = 1.
- Outputs hold between edges. There is no combinational path from inputs to outputs.

## Configuration
- `SUB32_OVF_EN` defined:
  - Adds the `ovf` port and register.
  - `ovf` = (Ra[31] ≠ Rb[31]) and (diff[31] ≠ Ra[31]), computed from the same diff as `sum`.
  - `ovf` is cleared by reset.
- `SUB32_OVF_EN` undefined:
  - The `ovf` port and logic are absent.
  - `sum` and `cout` behaviour is unchanged.

## Structure
- Package `sub32_pkg`:
  - `SUB32_WIDTH` = 32.
  - `SUB32_SLICE` = 4.
  - Typedef `word_t` (logic [31:0]).
- Sub-module `sub_4bit_bla`:
  - Inputs: a[3:0], b[3:0], bin.
  - Outputs: d[3:0], bout, plus group generate/propagate.
  - Instantiated 8× in a generate loop.
- Top level contains only the slice chain, the optional overflow logic and the output register.

## Test plan
- Reset: hold `clr_n` = 0 for 2 edges with Ra = 5, Rb = 1 → `sum` = 0, `cout` = 0 (and `ovf` = 0).
- Ra = 0x9, Rb = 0x1, cin = 0 → one edge later `sum` = 0x0000_0008, `cout` = 0.
- Ra = 0xFFFF_FFFF, Rb = 0x0000_00FF, cin = 1 → `sum` = 0xFFFF_FEFF, `cout` = 0.
- Ra = 0, Rb = 1, cin = 0 → `sum` = 0xFFFF_FFFF, `cout` = 1.
- Ra = 0, Rb = 0, cin = 1 → `sum` = 0xFFFF_FFFF, `cout` = 1.
- Ra = 0x8000_0000, Rb = 1, cin = 0 → `sum` = 0x7FFF_FFFF, `cout` = 0, `ovf` = 1 when enabled.
  - Then assert `clr_n` = 0 on the next edge → outputs return to 0.
